// File: rtl/alu_cmd_issuer.sv
// Command-side driver for the combinational 8-bit ALU: queues {opcode,a,b}
// commands, drives the ALU one at a time, screens illegal ops, returns results.
`ifndef OP_NOP
`define OP_NOP 4'h0
`define OP_ADD 4'h1
`define OP_SUB 4'h2
`define OP_MUL 4'h3
`define OP_DIV 4'h4
`define OP_AND 4'h5
`define OP_OR  4'h6
`define OP_XOR 4'h7
`define OP_CLR 4'h8
`endif

module alu_cmd_issuer #(
   parameter int DEPTH = 4,
   parameter int DW    = 8,
   parameter int RW    = 16,
   parameter int OPW   = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [OPW-1:0] cmd_opcode,
   input  logic [DW-1:0]  cmd_a,
   input  logic [DW-1:0]  cmd_b,
   output logic [OPW-1:0] alu_opcode,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   input  logic [RW-1:0]  alu_result,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [RW-1:0]  rsp_result,
   output logic [OPW-1:0] rsp_opcode,
   output logic           rsp_err,
   output logic           busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = DEPTH + 1;
   localparam int EW = OPW + 2 * DW;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;

   state_t         state_q, state_d;
   logic [EW-1:0]  mem_q [DEPTH];
   logic [EW-1:0]  mem_d [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           fresh_q, fresh_d;
   logic [OPW-1:0] alu_opcode_q, alu_opcode_d;
   logic [DW-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [RW-1:0]  rsp_result_q, rsp_result_d;
   logic [OPW-1:0] rsp_opcode_q, rsp_opcode_d;
   logic           rsp_err_q, rsp_err_d;

   logic           push, pop, op_legal;
   logic [EW-1:0]  head;
   logic [OPW-1:0] head_op;
   logic [DW-1:0]  head_a, head_b;

   assign head    = mem_q[rd_ptr_q];
   assign head_op = head[EW-1 -: OPW];
   assign head_a  = head[2*DW-1 -: DW];
   assign head_b  = head[DW-1:0];

   always_comb begin
      op_legal = 1'b0;
      case (head_op)
         OPW'(`OP_NOP), OPW'(`OP_ADD), OPW'(`OP_SUB), OPW'(`OP_MUL), OPW'(`OP_DIV),
         OPW'(`OP_AND), OPW'(`OP_OR),  OPW'(`OP_XOR), OPW'(`OP_CLR): op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rsp_result_d = rsp_result_q;
      rsp_opcode_d = rsp_opcode_q;
      rsp_err_d    = rsp_err_q;
      pop          = 1'b0;
      push         = cmd_valid && (count_q != FULL_CNT);
      // A slot written into an empty queue is readable only from the next cycle on.
      fresh_d      = push && (count_q == '0);

      case (state_q)
         IDLE: begin
            if ((count_q != '0) && !fresh_q) begin
               pop          = 1'b1;
               rsp_opcode_d = head_op;
               if (!op_legal || ((head_op == OPW'(`OP_DIV)) && (head_b == '0))) begin
                  rsp_result_d = '1;
                  rsp_err_d    = 1'b1;
                  state_d      = RESP;
               end else if ((head_op == OPW'(`OP_NOP)) || (head_op == OPW'(`OP_CLR))) begin
                  rsp_result_d = '0;
                  rsp_err_d    = 1'b0;
                  state_d      = RESP;
               end else begin
                  alu_opcode_d = head_op;
                  alu_a_d      = head_a;
                  alu_b_d      = head_b;
                  state_d      = DRIVE;
               end
            end
         end
         DRIVE: state_d = CAPTURE;
         CAPTURE: begin
            rsp_result_d = alu_result;
            rsp_err_d    = 1'b0;
            alu_opcode_d = OPW'(`OP_NOP);
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = {cmd_opcode, cmd_a, cmd_b};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         fresh_q      <= 1'b0;
         alu_opcode_q <= OPW'(`OP_NOP);
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rsp_result_q <= '0;
         rsp_opcode_q <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         fresh_q      <= fresh_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp_result_q <= rsp_result_d;
         rsp_opcode_q <= rsp_opcode_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign cmd_ready  = (count_q != FULL_CNT);
   assign alu_opcode = alu_opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_result = rsp_result_q;
   assign rsp_opcode = rsp_opcode_q;
   assign rsp_err    = rsp_err_q;
   assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule
